// File: rtl/lzw_pkg.sv
// Shared constants and FSM state type for the LZW decode unwinder.
// FIRST_FREE depends on LZW_CLEAR_CODE_EN.
package lzw_pkg;
   localparam int CODE_W      = 13;
   localparam int CHAR_W      = 8;
   localparam int DICT_SIZE   = 4096;
   localparam int STACK_DEPTH = 4096;
   localparam int LIT_LIMIT   = 256;
   localparam int CLEAR_CODE  = 256;
`ifdef LZW_CLEAR_CODE_EN
   localparam int FIRST_FREE  = CLEAR_CODE + 1;
`else
   localparam int FIRST_FREE  = LIT_LIMIT;
`endif
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int SAW   = $clog2(STACK_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_UPDATE,
      S_POP
   } state_e;
endpackage

// File: rtl/lzw_char_stack.sv
// Character LIFO; one or two pushes per cycle, one pop per cycle.
// The second pushed byte lands on top.
module lzw_char_stack
   import lzw_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              push2_i,
   input  logic [CHAR_W-1:0] d0_i,
   input  logic [CHAR_W-1:0] d1_i,
   input  logic              pop_i,
   output logic [CHAR_W-1:0] top_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              empty_o
);
   logic [CHAR_W-1:0] mem_q [STACK_DEPTH];
   logic [CNT_W-1:0]  cnt_q;
   logic [SAW-1:0]    wr0;
   logic [SAW-1:0]    wr1;
   logic [SAW-1:0]    rd;

   assign wr0 = cnt_q[SAW-1:0];
   assign wr1 = wr0 + SAW'(1);
   assign rd  = wr0 - SAW'(1);

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr0] <= d0_i;
         if (push2_i) mem_q[wr1] <= d1_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (pop_i) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end else if (push_i) begin
         cnt_q <= cnt_q + (push2_i ? CNT_W'(2) : CNT_W'(1));
      end
   end

   assign top_o   = mem_q[rd];
   assign count_o = cnt_q;
   assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/lzw_decode_unwinder.sv
// LZW decode unwinder: walks prefix/append chains, emits bytes via a LIFO.
// Optional CLEAR code (256) support under LZW_CLEAR_CODE_EN.
module lzw_decode_unwinder
   import lzw_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [CODE_W-1:0] in_code,
   output logic              in_ready,
   output logic              out_valid,
   output logic [CHAR_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic [CODE_W-1:0] dict_addr,
   output logic              wea_pcram,
   output logic              wea_acram,
   output logic [CODE_W-1:0] string_data,
   output logic [CHAR_W-1:0] char_data,
   input  logic [CODE_W-1:0] dict_prefix_data,
   input  logic [CHAR_W-1:0] dict_append_data,
   output logic              err
);
   localparam logic [CODE_W-1:0] LIT = CODE_W'(LIT_LIMIT);
   localparam logic [CODE_W-1:0] FF  = CODE_W'(FIRST_FREE);
   localparam logic [CODE_W-1:0] DSZ = CODE_W'(DICT_SIZE);
   localparam logic [CNT_W-1:0]  ONE = CNT_W'(1);

   state_e            state_q;
   logic              in_ready_q, out_valid_q, wea_q, err_q, prev_valid_q;
   logic [CODE_W-1:0] addr_q, str_q, code_q, prev_code_q, next_free_q;
   logic [CHAR_W-1:0] chr_q, first_q, prev_first_q;

   logic              accept, is_lit, is_dict, is_kwk, is_clr;
   logic              prev_lit, pre_lit, enter_upd;
   logic [CHAR_W-1:0] upd_first;
   logic              push, push2, pop, stk_empty;
   logic [CHAR_W-1:0] d0, d1, top;
   logic [CNT_W-1:0]  count;

   assign accept   = (state_q == S_IDLE) && in_valid && in_ready_q;
   assign is_lit   = in_code < LIT;
   assign is_dict  = (in_code >= FF) && (in_code < next_free_q);
   assign is_kwk   = (in_code == next_free_q) && prev_valid_q
                     && (next_free_q < DSZ);
`ifdef LZW_CLEAR_CODE_EN
   assign is_clr   = (in_code == CODE_W'(CLEAR_CODE));
`else
   assign is_clr   = 1'b0;
`endif
   assign prev_lit = prev_code_q < LIT;
   assign pre_lit  = dict_prefix_data < LIT;

   // Stack control; last char pushed first so the first char pops first.
   always_comb begin
      push      = 1'b0;
      push2     = 1'b0;
      d0        = '0;
      d1        = '0;
      pop       = 1'b0;
      enter_upd = 1'b0;
      upd_first = '0;
      unique case (state_q)
         S_IDLE: begin
            if (accept && is_lit) begin
               push      = 1'b1;
               d0        = in_code[CHAR_W-1:0];
               enter_upd = 1'b1;
               upd_first = in_code[CHAR_W-1:0];
            end else if (accept && is_kwk) begin
               push = 1'b1;
               d0   = prev_first_q;
               if (prev_lit) begin
                  push2     = 1'b1;
                  d1        = prev_code_q[CHAR_W-1:0];
                  enter_upd = 1'b1;
                  upd_first = prev_code_q[CHAR_W-1:0];
               end
            end
         end
         S_CAP: begin
            push = 1'b1;
            d0   = dict_append_data;
            if (pre_lit) begin
               push2     = 1'b1;
               d1        = dict_prefix_data[CHAR_W-1:0];
               enter_upd = 1'b1;
               upd_first = dict_prefix_data[CHAR_W-1:0];
            end
         end
         S_POP:   pop = out_valid_q && out_ready && !stk_empty;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         wea_q        <= 1'b0;
         err_q        <= 1'b0;
         prev_valid_q <= 1'b0;
         addr_q       <= '0;
         str_q        <= '0;
         chr_q        <= '0;
         code_q       <= '0;
         first_q      <= '0;
         prev_code_q  <= '0;
         prev_first_q <= '0;
         next_free_q  <= FF;
      end else begin
         err_q <= 1'b0;
         wea_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  unique case (1'b1)
                     is_lit: begin
                        code_q     <= in_code;
                        in_ready_q <= 1'b0;
                     end
                     is_dict: begin
                        code_q     <= in_code;
                        addr_q     <= in_code;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RD;
                     end
                     is_kwk: begin
                        code_q     <= in_code;
                        in_ready_q <= 1'b0;
                        if (!prev_lit) begin
                           addr_q  <= prev_code_q;
                           state_q <= S_RD;
                        end
                     end
                     is_clr: begin
                        next_free_q  <= FF;
                        prev_valid_q <= 1'b0;
                     end
                     default: err_q <= 1'b1;
                  endcase
               end
            end
            S_RD: state_q <= S_CAP;
            S_CAP: begin
               if (!pre_lit) begin
                  addr_q  <= dict_prefix_data;
                  state_q <= S_RD;
               end
            end
            S_UPDATE: begin
               if (wea_q) next_free_q <= next_free_q + CODE_W'(1);
               prev_code_q  <= code_q;
               prev_first_q <= first_q;
               prev_valid_q <= 1'b1;
               out_valid_q  <= 1'b1;
               state_q      <= S_POP;
            end
            S_POP: begin
               if (pop && count == ONE) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Root reached: the dictionary write is presented during UPDATE.
         if (enter_upd) begin
            state_q <= S_UPDATE;
            first_q <= upd_first;
            if (prev_valid_q && next_free_q < DSZ) begin
               addr_q <= next_free_q;
               wea_q  <= 1'b1;
               str_q  <= prev_code_q;
               chr_q  <= upd_first;
            end
         end
      end
   end

   lzw_char_stack u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .push2_i (push2),
      .d0_i    (d0),
      .d1_i    (d1),
      .pop_i   (pop),
      .top_o   (top),
      .count_o (count),
      .empty_o (stk_empty)
   );

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_valid_q ? top : '0;
   assign out_last    = out_valid_q && (count == ONE);
   assign dict_addr   = addr_q;
   assign wea_pcram   = wea_q;
   assign wea_acram   = wea_q;
   assign string_data = str_q;
   assign char_data   = chr_q;
   assign err         = err_q;
endmodule

// File: tb/tb_lzw_decode_unwinder.sv
// Randomized bench for lzw_decode_unwinder against a string-level LZW model.
// Includes a registered dictionary RAM model with 1-cycle read latency.
module tb_lzw_decode_unwinder;
   import lzw_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid, in_ready, out_valid, out_last, out_ready;
   logic [CODE_W-1:0] in_code, dict_addr, string_data, dict_prefix_data;
   logic [CHAR_W-1:0] out_data, char_data, dict_append_data;
   logic              wea_pcram, wea_acram, err;

   always #5 clk = ~clk;

   lzw_decode_unwinder dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_code          (in_code),
      .in_ready         (in_ready),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_last         (out_last),
      .out_ready        (out_ready),
      .dict_addr        (dict_addr),
      .wea_pcram        (wea_pcram),
      .wea_acram        (wea_acram),
      .string_data      (string_data),
      .char_data        (char_data),
      .dict_prefix_data (dict_prefix_data),
      .dict_append_data (dict_append_data),
      .err              (err)
   );

   logic [CODE_W-1:0] pram [8192];
   logic [CHAR_W-1:0] aram [8192];
   always @(posedge clk) begin
      if (wea_pcram) pram[dict_addr] <= string_data;
      if (wea_acram) aram[dict_addr] <= char_data;
      dict_prefix_data <= pram[dict_addr];
      dict_append_data <= aram[dict_addr];
   end

   int n_chk = 0;
   int n_err = 0;
   bit rnd_rdy = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Observed behaviour
   int         cyc = 0;
   logic [7:0] got_b [$];
   bit         got_l [$];
   int         acc_cyc, fov_cyc, n_wr, wr_a, wr_p, wr_c, n_errp;
   bit         fov_seen;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) acc_cyc = cyc;
         if (out_valid && !fov_seen) begin
            fov_seen = 1;
            fov_cyc  = cyc;
         end
         if (out_valid && out_ready) begin
            got_b.push_back(out_data);
            got_l.push_back(out_last);
         end
         if (wea_pcram || wea_acram) begin
            n_wr++;
            wr_a = dict_addr;
            wr_p = string_data;
            wr_c = char_data;
         end
         if (err) n_errp++;
      end
   end

   // Reference model: dictionary of (prefix, char) and decoded strings
   int         m_pre [DICT_SIZE];
   logic [7:0] m_app [DICT_SIZE];
   int         m_next, m_pc;
   bit         m_pv;
   logic [7:0] e_q [$];
   bit         e_err, e_wr;
   int         e_wa, e_wp, e_wc, e_links;

   task automatic model_reset();
      m_next = FIRST_FREE;
      m_pv   = 0;
      m_pc   = 0;
   endtask

   task automatic expand(input int c);
      int x;
      x = c;
      while (x >= 256) begin
         e_q.push_front(m_app[x]);
         x = m_pre[x];
      end
      e_q.push_front(x[7:0]);
   endtask

   task automatic model_step(input int code);
      e_q.delete();
      e_err   = 0;
      e_wr    = 0;
      e_links = 0;
      if (code >= DICT_SIZE) begin
         e_err = 1;
`ifdef LZW_CLEAR_CODE_EN
      end else if (code == CLEAR_CODE) begin
         m_next = FIRST_FREE;
         m_pv   = 0;
         return;
`endif
      end else if (code < 256) begin
         e_q.push_back(code[7:0]);
      end else if (code >= FIRST_FREE && code < m_next) begin
         expand(code);
         e_links = e_q.size() - 1;
      end else if (code == m_next && m_pv) begin
         expand(m_pc);
         e_links = e_q.size() - 1;
         e_q.push_back(e_q[0]);
      end else begin
         e_err = 1;
      end
      if (e_err) return;
      if (m_pv && m_next < DICT_SIZE) begin
         e_wr          = 1;
         e_wa          = m_next;
         e_wp          = m_pc;
         e_wc          = e_q[0];
         m_pre[m_next] = m_pc;
         m_app[m_next] = e_q[0];
         m_next++;
      end
      m_pc = code;
      m_pv = 1;
   endtask

   function automatic logic pick_rdy();
      return rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
   endfunction

   task automatic chk_reset_outs();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_dict_addr", dict_addr, 0);
      chk("rst_wea_p", wea_pcram, 0);
      chk("rst_wea_a", wea_acram, 0);
      chk("rst_string", string_data, 0);
      chk("rst_char", char_data, 0);
      chk("rst_err", err, 0);
   endtask

   task automatic send(input int code, input bit stall);
      int n;
      bit st;
      model_step(code);
      st = stall && (e_q.size() > 1);
      got_b.delete();
      got_l.delete();
      n_wr = 0; n_errp = 0; fov_seen = 0; acc_cyc = 0; fov_cyc = 0;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("in_ready", in_ready, 1);
      out_ready = !st;
      in_valid  = 1;
      in_code   = CODE_W'(code);
      @(posedge clk); #1;
      in_valid = 0;
      in_code  = CODE_W'($urandom);
      if (st) begin
         n = 0;
         while (!out_valid && n < 20000) begin
            @(posedge clk); #1; n++;
         end
         out_ready = 1;
         @(posedge clk); #1;
         out_ready = 0;
         repeat (5) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, e_q[1]);
            @(posedge clk); #1;
         end
      end
      n = 0;
      repeat (2) begin
         @(posedge clk); #1; out_ready = pick_rdy();
      end
      while (!in_ready && n < 20000) begin
         @(posedge clk); #1; out_ready = pick_rdy(); n++;
      end
      chk("done", in_ready, 1);
      out_ready = 1;
      chk("err", n_errp, e_err);
      chk("nbytes", got_b.size(), e_q.size());
      chk("ov_seen", fov_seen, e_q.size() > 0);
      for (int i = 0; i < e_q.size(); i++) begin
         if (i < got_b.size()) begin
            chk("byte", got_b[i], e_q[i]);
            chk("last", got_l[i], i == e_q.size() - 1);
         end
      end
      chk("nwr", n_wr, e_wr);
      if (e_wr && n_wr == 1) begin
         chk("wr_addr", wr_a, e_wa);
         chk("wr_prefix", wr_p, e_wp);
         chk("wr_char", wr_c, e_wc);
      end
      if (fov_seen) chk("latency", fov_cyc - acc_cyc, 2 + 2 * e_links);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0;
      #2;
      chk_reset_outs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
   endtask

   task automatic rand_code(output int code);
      int r;
      r = $urandom_range(0, 99);
      code = $urandom_range(0, 255);
      if (r < 60 && r >= 30 && m_next > FIRST_FREE)
         code = $urandom_range(FIRST_FREE, m_next - 1);
      else if (r < 75 && r >= 60 && m_next > FIRST_FREE)
         code = m_next - 1;
      else if (r < 90 && r >= 75)
         code = m_next;
      else if (r < 95 && r >= 90)
         code = $urandom_range(8191, m_next + 1);
`ifdef LZW_CLEAR_CODE_EN
      else if (r >= 95)
         code = CLEAR_CODE;
`endif
   endtask

   initial begin
      int code;
      int n;
      in_valid  = 0;
      in_code   = '0;
      out_ready = 1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs();
      rst_n = 1;

      send(65, 0);
      send(66, 0);
      send(FIRST_FREE, 0);
      send(300, 0);
      send(66, 0);
`ifdef LZW_CLEAR_CODE_EN
      send(CLEAR_CODE, 0);
      send(65, 0);
      send(FIRST_FREE, 0);
`endif

      do_reset();
      send(65, 0);
      send(m_next, 0);

      // Grow a chain, then stall mid-string
      repeat (5) send(m_next, 0);
      send(m_next - 1, 1);

      rnd_rdy = 1;
      for (int i = 0; i < 400; i++) begin
         rand_code(code);
         send(code, $urandom_range(0, 9) == 0);
      end

      rnd_rdy = 0;
      while (m_next < DICT_SIZE && m_pv) send($urandom_range(0, 255), 0);
      rnd_rdy = 1;
      send(DICT_SIZE, 0);
      send(DICT_SIZE - 1, 1);
      for (int i = 0; i < 30; i++) begin
         rand_code(code);
         send(code, 0);
      end

      // Reset while popping a 3-byte string
      rnd_rdy = 0;
      do_reset();
      send(65, 0);
      send(m_next, 0);
      send(m_next, 0);
      out_ready = 0;
      in_valid  = 1;
      in_code   = CODE_W'(m_next);
      @(posedge clk); #1;
      in_valid = 0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("mid_valid", out_valid, 1);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("mid_data", out_data, 65);
      chk("mid_last", out_last, 0);
      #2;
      rst_n = 0;
      #1;
      chk_reset_outs();
      @(posedge clk); #1;
      rst_n     = 1;
      out_ready = 1;
      model_reset();
      send(65, 0);
      send(66, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/lzw_decode_unwinder.md
Name: lzw_decode_unwinder

Overview:
LZW decoder string-reconstruction engine; the decode-side counterpart of the encoder's dictionary RAM. It accepts one code per handshake and walks the prefix/append dictionary chain to the root literal. Characters are pushed onto a LIFO, then emitted first-character-first on a byte stream. It also builds the decoder dictionary by writing (previous code, first char) entries through the dictionary_ram write ports.

Parameters:
CODE_W, 13, code / prefix width (matches dictionary prefix data)
CHAR_W, 8, character width
DICT_SIZE, 4096, dictionary entries; codes >= DICT_SIZE are illegal
STACK_DEPTH, 4096, LIFO depth; never smaller than DICT_SIZE-256+1

Ports:
clk  in  1  system clock
rst_n  in  1  system reset, asynchronous, active low
in_valid  in  1  code valid
in_code  in  CODE_W  input code
in_ready  out  1  code accepted when in_valid & in_ready
out_valid  out  1  output byte valid
out_data  out  CHAR_W  output byte
out_last  out  1  last byte of current code's string
out_ready  in  1  consumer ready
dict_addr  out  CODE_W  dictionary address (shared read/write)
wea_pcram  out  1  prefix RAM write enable
wea_acram  out  1  append RAM write enable
string_data  out  CODE_W  prefix write data
char_data  out  CHAR_W  append write data
dict_prefix_data  in  CODE_W  prefix read data, registered RAM, 1-cycle latency
dict_append_data  in  CHAR_W  append read data, 1-cycle latency
err  out  1  one-cycle pulse: illegal code dropped

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, dict_addr=0, wea_*=0, string_data=0, char_data=0, err=0. Internal reset values: next_free=FIRST_FREE, prev_valid=0, stack empty, state IDLE.
- States: IDLE, RD, CAP, UPDATE, POP. in_ready=1 only in IDLE.
- IDLE accept:
  - code<256: push code[7:0]; first_char=code[7:0]; ->UPDATE.
  - FIRST_FREE<=code<next_free: cur=code; ->RD.
  - code==next_free && prev_valid (KwKwK): push prev_first; if prev_code<256, push prev_code[7:0] and ->UPDATE; else cur=prev_code and ->RD.
  - Otherwise: err pulse next cycle; no dictionary or stack change; stay IDLE.
- RD: dict_addr=cur; ->CAP.
- CAP: push dict_append_data; if dict_prefix_data<256, push its low byte, set first_char to it, ->UPDATE; else cur=dict_prefix_data, ->RD.
- Chain walk costs 2 cycles per dictionary link.
- UPDATE (exactly 1 cycle):
  - If prev_valid && next_free<DICT_SIZE: dict_addr=next_free, wea_pcram=wea_acram=1, string_data=prev_code, char_data=first_char, then next_free++.
  - Always: prev_code=accepted code, prev_first=first_char, prev_valid=1; ->POP.
  - Writes and reads never overlap.
- POP: out_valid=1, out_data=stack top. A byte pops only when out_valid & out_ready; out_data is held stable while out_ready=0. out_last=1 when stack count==1. After the last pop, ->IDLE (in_ready=1 the following cycle).
- Latency: literal code accepted in cycle 0 -> first out_valid in cycle 2. Code with L links -> first out_valid in cycle 2+2L.
- Dictionary full (next_free==DICT_SIZE): decoding continues, writes are suppressed, next_free saturates.
- Reset asserted mid-string: stack is discarded and all state is reinitialised asynchronously.
- FIRST_FREE = 256 without the optional feature, 257 with it.

Optional Feature:
LZW_CLEAR_CODE_EN.
- Defined: code 256 is CLEAR. Accepting it sets next_free=257 and prev_valid=0, produces no output and no err, and in_ready stays 1. Codes then start at 257.
- Undefined: 256 is an ordinary dictionary code and FIRST_FREE=256.

Decomposition:
- Package lzw_pkg: CODE_W, CHAR_W, DICT_SIZE, LIT_LIMIT=256, CLEAR_CODE=256, FIRST_FREE (macro-dependent), state enum.
- Sub-module lzw_char_stack: synchronous LIFO with push/pop/top/count/empty, depth STACK_DEPTH; a push/pop in the same cycle never occurs by construction.
- The bench pairs this block with dictionary_ram.

Test Plan:
- Literals 65, 66: outputs 65(last), 66(last). On code 66's UPDATE: dict_addr=256, string_data=65, char_data=66, both wea=1. next_free=257.
- Then code 256: outputs 65, 66 (last on 66). First out_valid 4 cycles after accept. Write 257=(66,65).
- KwKwK: reset, 65 then 256: outputs 65, then 65, 65(last). Write 256=(65,65).
- Illegal: with next_free=257, send 300: err pulses once, no out_valid, no wea, next_free unchanged. Next legal code decodes normally.
- Backpressure/full: hold out_ready=0 for 5 cycles mid-string -> out_data/out_valid stable. Drive next_free to 4096 -> no further wea, decoding still correct.
- Reset mid-POP of a 3-byte string: outputs at reset values immediately. After release, 65 decodes with no dictionary write.
